// File: rtl/rob_commit.sv
// Reorder buffer commit stage: in-order retirement with a retirement RAT that hands old mappings back to rename.
// Optional ROB_FLUSH_EN adds a Flush input that empties the buffer without committing anything.
module rob_commit #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
`ifdef ROB_FLUSH_EN
   input  logic             Flush,
`endif
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_arch_reg,
   input  logic [5:0]       alloc_phy_reg,
   input  logic             alloc_reg_write,
   input  logic [31:0]      alloc_PC,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             complete_valid,
   input  logic [TAG_W-1:0] complete_tag,
   output logic             commit_valid,
   output logic [31:0]      commit_PC,
   output logic             FreeList_WB,
   output logic [5:0]       reg_FreeList_WB,
   output logic [TAG_W:0]   rob_count,
   output logic             rob_empty
);

   // Handshake: an allocation is taken on a rising edge where alloc_valid && alloc_ready;
   // alloc_ready depends only on the current occupancy, never on alloc_valid.
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [TAG_W:0]   head, tail, count;
   logic [TAG_W-1:0] head_idx, tail_idx;
   logic [DEPTH-1:0] ent_valid, ent_done, ent_rw;
   logic [4:0]       ent_arch [DEPTH];
   logic [5:0]       ent_phy  [DEPTH];
   logic [31:0]      ent_pc   [DEPTH];
   logic [5:0]       rrat     [32];
   logic             flush_w, do_alloc, do_commit, do_free;

`ifdef ROB_FLUSH_EN
   assign flush_w = Flush;
`else
   assign flush_w = 1'b0;
`endif

   assign head_idx    = head[TAG_W-1:0];
   assign tail_idx    = tail[TAG_W-1:0];
   assign count       = tail - head;
   assign rob_count   = count;
   assign rob_empty   = (count == '0);
   assign alloc_ready = (count < FULL_CNT);
   assign alloc_tag   = tail_idx;

   // Commit looks at the pre-edge done bit, so a head completing this edge retires next edge.
   assign do_alloc  = alloc_valid && alloc_ready && !flush_w;
   assign do_commit = ent_valid[head_idx] && ent_done[head_idx] && !flush_w;
   assign do_free   = do_commit && ent_rw[head_idx] && (ent_arch[head_idx] != 5'd0);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head            <= '0;
         tail            <= '0;
         ent_valid       <= '0;
         ent_done        <= '0;
         commit_valid    <= 1'b0;
         commit_PC       <= '0;
         FreeList_WB     <= 1'b0;
         reg_FreeList_WB <= '0;
         for (int i = 0; i < 32; i++) rrat[i] <= 6'(i);
      end else begin
         commit_valid    <= do_commit;
         commit_PC       <= do_commit ? ent_pc[head_idx] : '0;
         FreeList_WB     <= do_free;
         reg_FreeList_WB <= do_free ? rrat[ent_arch[head_idx]] : '0;
         if (do_free) rrat[ent_arch[head_idx]] <= ent_phy[head_idx];
         if (flush_w) begin
            tail      <= head;
            ent_valid <= '0;
            ent_done  <= '0;
         end else begin
            if (complete_valid && ent_valid[complete_tag]) ent_done[complete_tag] <= 1'b1;
            // The retiring entry's clear must override a late repeat completion of the same tag.
            if (do_commit) begin
               ent_valid[head_idx] <= 1'b0;
               ent_done[head_idx]  <= 1'b0;
               head                <= head + 1'b1;
            end
            if (do_alloc) begin
               ent_valid[tail_idx] <= 1'b1;
               ent_done[tail_idx]  <= 1'b0;
               tail                <= tail + 1'b1;
            end
         end
      end
   end

   // Payload needs no reset: it is only read behind a set valid bit.
   always_ff @(posedge CLK) begin
      if (do_alloc) begin
         ent_arch[tail_idx] <= alloc_arch_reg;
         ent_phy[tail_idx]  <= alloc_phy_reg;
         ent_rw[tail_idx]   <= alloc_reg_write;
         ent_pc[tail_idx]   <= alloc_PC;
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic checked against a program-order queue model.
module tb_rob_commit;
   localparam int DEPTH = 16;
   localparam int TAG_W = 4;

   logic             CLK, RESET, flush;
   logic             alloc_valid, alloc_reg_write, complete_valid;
   logic [4:0]       alloc_arch_reg;
   logic [5:0]       alloc_phy_reg;
   logic [31:0]      alloc_PC;
   logic             alloc_ready, commit_valid, FreeList_WB, rob_empty;
   logic [TAG_W-1:0] alloc_tag, complete_tag;
   logic [31:0]      commit_PC;
   logic [5:0]       reg_FreeList_WB;
   logic [TAG_W:0]   rob_count;

   rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .CLK(CLK), .RESET(RESET),
`ifdef ROB_FLUSH_EN
      .Flush(flush),
`endif
      .alloc_valid(alloc_valid), .alloc_arch_reg(alloc_arch_reg), .alloc_phy_reg(alloc_phy_reg),
      .alloc_reg_write(alloc_reg_write), .alloc_PC(alloc_PC), .alloc_ready(alloc_ready),
      .alloc_tag(alloc_tag), .complete_valid(complete_valid), .complete_tag(complete_tag),
      .commit_valid(commit_valid), .commit_PC(commit_PC), .FreeList_WB(FreeList_WB),
      .reg_FreeList_WB(reg_FreeList_WB), .rob_count(rob_count), .rob_empty(rob_empty)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // reference model: in-flight instructions in program order
   typedef struct { int tag; int arch; int phy; bit rw; bit done; } ent_t;
   ent_t        mq[$];
   logic [31:0] exp_q[$];
   int          rrat_m[32];
   int          tail_ctr;
   bit          e_cv, e_fw;
   logic [31:0] e_pc;
   int          e_freg;
   int          checks_total, checks_passed;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      for (int i = 0; i < 32; i++) rrat_m[i] = i;
      tail_ctr = 0;
      e_cv = 0; e_fw = 0; e_pc = 0; e_freg = 0;
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, "_commit_valid"}, commit_valid, e_cv);
      check({pfx, "_commit_PC"}, commit_PC, e_pc);
      check({pfx, "_FreeList_WB"}, FreeList_WB, e_fw);
      check({pfx, "_reg_FreeList_WB"}, reg_FreeList_WB, e_freg);
   endtask

   // driver: called at a falling edge, applies one cycle of inputs and checks the result
   task automatic step(input bit av, input int arch, input int phy, input bit rw,
                       input logic [31:0] pc, input bit cv, input int ctag);
      bit can_alloc;
      ent_t ne, hd;
      alloc_valid = av; alloc_arch_reg = arch[4:0]; alloc_phy_reg = phy[5:0];
      alloc_reg_write = rw; alloc_PC = pc; complete_valid = cv; complete_tag = ctag[TAG_W-1:0];
      check("rob_count", rob_count, mq.size());
      check("alloc_ready", alloc_ready, mq.size() < DEPTH);
      check("alloc_tag", alloc_tag, tail_ctr);
      check("rob_empty", rob_empty, mq.size() == 0);
      can_alloc = mq.size() < DEPTH;
      e_cv = 0; e_fw = 0; e_pc = 0; e_freg = 0;
      if (flush) begin
         tail_ctr = (tail_ctr - mq.size() + DEPTH) % DEPTH;
         mq.delete();
         exp_q.delete();
      end else begin
         if (mq.size() > 0 && mq[0].done) begin
            hd = mq.pop_front();
            e_cv = 1;
            e_pc = exp_q.pop_front();
            if (hd.rw && hd.arch != 0) begin
               e_fw = 1;
               e_freg = rrat_m[hd.arch];
               rrat_m[hd.arch] = hd.phy;
            end
         end
         if (cv) foreach (mq[i]) if (mq[i].tag == ctag) mq[i].done = 1;
         if (av && can_alloc) begin
            ne.tag = tail_ctr; ne.arch = arch; ne.phy = phy; ne.rw = rw; ne.done = 0;
            mq.push_back(ne);
            exp_q.push_back(pc);
            tail_ctr = (tail_ctr + 1) % DEPTH;
         end
      end
      @(posedge CLK);
      @(negedge CLK);
      check_outputs("step");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0, 0);
   endtask

   task automatic alloc(input int arch, input int phy, input bit rw, input logic [31:0] pc);
      step(1, arch, phy, rw, pc, 0, 0);
   endtask

   task automatic complete(input int tag);
      step(0, 0, 0, 0, 32'h0, 1, tag);
   endtask

   // asserts reset off-edge, checks the asynchronous clear, releases on the next falling edge
   task automatic do_reset();
      RESET = 1'b0;
      alloc_valid = 0; complete_valid = 0; flush = 0;
      model_reset();
      #1;
      check_outputs("reset");
      check("reset_rob_count", rob_count, 0);
      check("reset_rob_empty", rob_empty, 1);
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   initial begin
      int ctag;
      checks_total = 0; checks_passed = 0; flush = 0;
      alloc_arch_reg = 0; alloc_phy_reg = 0; alloc_reg_write = 0; alloc_PC = 0; complete_tag = 0;
      do_reset();

      // single instruction retires and frees the initial mapping of r3
      alloc(3, 40, 1, 32'h100);
      complete(0);
      idle(1);
      check("r3_free_pulse", FreeList_WB, 1);
      check("r3_free_reg", reg_FreeList_WB, 3);
      alloc(3, 41, 1, 32'h104);
      complete(1);
      idle(1);
      check("r3_rrat_updated", reg_FreeList_WB, 40);

      // out-of-order completion, in-order commit
      do_reset();
      alloc(7, 20, 1, 32'h200); alloc(8, 21, 1, 32'h204); alloc(9, 22, 1, 32'h208);
      complete(2); complete(0); complete(1);
      idle(4);

      // full buffer: allocation held until the edge after the head commits
      do_reset();
      for (int i = 0; i < DEPTH; i++) alloc(i % 32, 32 + i, 1, 32'h1000 + 4 * i);
      check("full_alloc_ready", alloc_ready, 0);
      check("full_rob_count", rob_count, DEPTH);
      step(1, 12, 50, 1, 32'h2000, 1, 0);
      step(1, 12, 50, 1, 32'h2000, 0, 0);
      step(1, 12, 50, 1, 32'h2000, 0, 0);
      check("wrap_count", rob_count, DEPTH);
      idle(1);

      // arch 0 and non-writing commits, completion to an invalid tag
      do_reset();
      alloc(0, 33, 1, 32'h300); alloc(5, 34, 0, 32'h304);
      complete(9); complete(0); complete(1);
      idle(1);
      check("nowrite_count", rob_count, 0);
      complete(4);
      idle(2);

      // random traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if (mq.size() > 0 && $urandom_range(3) != 0) ctag = mq[$urandom_range(mq.size() - 1)].tag;
         else ctag = $urandom_range(DEPTH - 1);
         step($urandom_range(9) < 6, $urandom_range(31), $urandom_range(63), $urandom_range(4) != 0,
              $urandom, $urandom_range(9) < 7, ctag);
      end

`ifdef ROB_FLUSH_EN
      do_reset();
      for (int i = 0; i < 5; i++) alloc(i + 1, 40 + i, 1, 32'h500 + 4 * i);
      complete(0);
      flush = 1;
      step(1, 9, 60, 1, 32'h600, 0, 0);
      flush = 0;
      check("flush_count", rob_count, 0);
      idle(2);
`endif

      // reset while a commit pulse is on the outputs
      do_reset();
      alloc(4, 44, 1, 32'h700);
      complete(0);
      idle(1);
      check("pre_reset_commit", commit_valid, 1);
      #3;
      do_reset();
      idle(2);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameter DEPTH, default 16, number of ROB entries (power of two, at least 4).
REQ-002 Parameter TAG_W, default 4, equals log2(DEPTH); width of entry tags.
REQ-003 CLK  input  1  clock, all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 alloc_valid  input  1  rename stage presents an instruction for allocation.
REQ-006 alloc_arch_reg  input  5  architectural destination register.
REQ-007 alloc_phy_reg  input  6  physical register taken from the free list for that destination.
REQ-008 alloc_reg_write  input  1  instruction writes a register.
REQ-009 alloc_PC  input  32  instruction PC (debug/trace).
REQ-010 alloc_ready  output  1  combinational, high when count < DEPTH.
REQ-011 alloc_tag  output  TAG_W  combinational, index of the entry that the next allocation receives (tail index).
REQ-012 complete_valid  input  1  execute writeback reports an instruction finished.
REQ-013 complete_tag  input  TAG_W  tag of the finished instruction.
REQ-014 commit_valid  output  1  registered, one-cycle pulse per retired instruction.
REQ-015 commit_PC  output  32  registered, PC of the retired instruction.
REQ-016 FreeList_WB  output  1  registered, one-cycle pulse returning a physical register to rename.
REQ-017 reg_FreeList_WB  output  6  registered, physical register being freed.
REQ-018 rob_count  output  TAG_W+1  registered, number of occupied entries.
REQ-019 rob_empty  output  1  combinational, high when rob_count == 0.

Function
REQ-020 Circular buffer; head/tail pointers each TAG_W+1 bits (extra wrap bit); count = tail - head modulo 2^(TAG_W+1); full when count == DEPTH.
REQ-021 Allocation occurs on an edge with alloc_valid && alloc_ready: entry[tail] gets valid=1, done=0, arch, phy, reg_write, PC; tail increments, wrapping DEPTH-1 -> 0 with the wrap bit toggled.
REQ-022 alloc_ready uses the pre-edge count; when full, allocation is refused even if a commit occurs in the same cycle.
REQ-023 Completion with complete_valid sets done=1 in entry[complete_tag] only if that entry is valid; completion to an invalid entry is ignored; a repeated completion is harmless.
REQ-024 Commit: at most one per cycle, in program order; on an edge where entry[head] is valid and done (pre-edge values), the entry is cleared, head increments, and commit_valid=1 and commit_PC=entry PC for the following cycle.
REQ-025 Completion of the head entry and its commit never occur in the same edge; the commit happens on the next edge at the earliest.
REQ-026 Retirement RAT (RRAT, 32 x 6 bits) holds the committed arch->phys map; on commit with reg_write=1 and arch != 0, FreeList_WB=1, reg_FreeList_WB=RRAT[arch] (old value), and RRAT[arch]=entry phy.
REQ-027 Commit with reg_write=0 or arch == 0: FreeList_WB=0, RRAT unchanged.
REQ-028 Without a commit, commit_valid, FreeList_WB, reg_FreeList_WB and commit_PC return to 0 on the next edge.
REQ-029 Allocation, completion and commit may all occur in one edge; count changes by +1, 0 or -1 accordingly.
REQ-030 Empty: no commit, outputs per REQ-028; allocation of a new entry and its commit never occur in the same edge.

Reset
REQ-031 When RESET is low, asynchronously: head=tail=0, all valid/done cleared, rob_count=0, commit_valid=0, commit_PC=0, FreeList_WB=0, reg_FreeList_WB=0, RRAT[i]=i for i=0..31.
REQ-032 Reset asserted mid-operation discards all in-flight entries with no commit pulses; operation resumes on the first edge after RESET goes high.

Configuration
REQ-033 Macro ROB_FLUSH_EN, when defined, adds port Flush  input  1; when high on an edge, tail=head, all valid/done cleared, count=0, no commit, commit outputs 0, RRAT unchanged; Flush has priority over allocation, completion and commit.
REQ-034 Without ROB_FLUSH_EN, the Flush port and its logic are absent; entries leave only by commit or reset.

Verification
REQ-035 Reset, then allocate arch 3 / phy 40 and complete tag 0 -> next edge commit_valid=1, FreeList_WB=1, reg_FreeList_WB=3, RRAT[3]=40.
REQ-036 Allocate tags 0,1,2 and complete in order 2,0,1 -> commits in order 0,1,2 on consecutive cycles, none before tag 0 is done.
REQ-037 Fill 16 entries -> alloc_ready=0, rob_count=16; complete head and hold alloc_valid -> allocation accepted only on the edge after the commit, tail wraps to 0.
REQ-038 Commit with arch 0 or reg_write=0 -> commit_valid=1, FreeList_WB=0; complete_valid to an invalid tag -> no state change.
REQ-039 With ROB_FLUSH_EN, 5 entries in flight and Flush with a simultaneous allocation -> rob_count=0, no commit pulse, allocation dropped; drop RESET mid-run -> all outputs 0 immediately.
